// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control path: opcodes, R-type func codes,
// ALU control codes, mul/div op and HI/LO read encodings, decode bundle.
package alu_ctrl_pkg;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type func codes
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  // ALU control codes for immediate/branch forms
  localparam logic [5:0] CTRL_NONE = 6'h00;
  localparam logic [5:0] CTRL_ADD  = 6'h20;
  localparam logic [5:0] CTRL_SUB  = 6'h22;
  localparam logic [5:0] CTRL_AND  = 6'h24;
  localparam logic [5:0] CTRL_OR   = 6'h25;
  localparam logic [5:0] CTRL_XOR  = 6'h26;
  localparam logic [5:0] CTRL_SLT  = 6'h2A;
  localparam logic [5:0] CTRL_SLTU = 6'h2B;
  localparam logic [5:0] CTRL_LUI  = 6'h3C;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    HILO_NONE = 2'b00,
    HILO_LO   = 2'b01,
    HILO_HI   = 2'b10
  } hilo_rd_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

  typedef struct packed {
    logic [5:0] ctrl;
    logic       op1_sel;
    logic       illegal;
    logic       is_md;
    md_op_t     md_op;
    hilo_rd_t   hilo_rd;
  } dec_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Purely combinational opcode/func decoder feeding the registered stage.
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
#(
  parameter bit MD_EN = 1'b1
) (
  input  logic [5:0] alu_op,
  input  logic [5:0] func,
  output dec_t       dec
);

  // Decode table; every unknown opcode/func falls through to illegal.
  always_comb begin
    dec         = '0;
    dec.md_op   = MD_MULT;
    dec.hilo_rd = HILO_NONE;
    case (alu_op)
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: dec.ctrl = CTRL_ADD;
      OP_BEQ, OP_BNE:                  dec.ctrl = CTRL_SUB;
      OP_SLTI:                         dec.ctrl = CTRL_SLT;
      OP_SLTIU:                        dec.ctrl = CTRL_SLTU;
      OP_LUI:                          dec.ctrl = CTRL_LUI;
      OP_ORI:                          dec.ctrl = CTRL_OR;
      OP_XORI:                         dec.ctrl = CTRL_XOR;
      OP_ANDI:                         dec.ctrl = CTRL_AND;
      OP_J:                            dec.ctrl = CTRL_NONE;
      OP_RTYPE: begin
        case (func)
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU, F_SLLV, F_SRLV, F_SRAV: dec.ctrl = func;
          F_SLL, F_SRL, F_SRA: begin
            dec.ctrl    = func;
            dec.op1_sel = 1'b1;
          end
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            // The low two func bits line up with the md_op encoding.
            if (MD_EN) begin
              dec.is_md = 1'b1;
              dec.md_op = md_op_t'(func[1:0]);
            end else begin
              dec.illegal = 1'b1;
            end
          end
          F_MFHI: begin
            if (MD_EN) begin
              dec.hilo_rd = HILO_HI;
            end else begin
              dec.illegal = 1'b1;
            end
          end
          F_MFLO: begin
            if (MD_EN) begin
              dec.hilo_rd = HILO_LO;
            end else begin
              dec.illegal = 1'b1;
            end
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control stage with valid/ready handshake and a mul/div
// sequencer that interlocks HI/LO consumers until the result is written.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter bit MD_EN     = 1'b1,
  parameter int MD_CYCLES = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [5:0] i_aluOp,
  input  logic [5:0] i_func,
  input  logic       i_hold,
  output logic       o_ready,
  output logic       o_valid,
  output logic [5:0] o_aluControl,
  output logic       o_ALUSrc_op1,
  output logic       o_illegal,
  output logic       o_md_start,
  output logic [1:0] o_md_op,
  output logic       o_md_busy,
  output logic       o_md_done,
  output logic [1:0] o_hilo_rd
);

  localparam int              CNT_W      = $clog2(MD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);

  dec_t             dec_s;
  md_state_t        state_r;
  md_state_t        state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             cnt_zero_s;
  logic             interlock_s;
  logic             accept_s;
  logic             md_done_nxt_s;

  alu_ctrl_dec #(.MD_EN(MD_EN)) u_dec (
    .alu_op (i_aluOp),
    .func   (i_func),
    .dec    (dec_s)
  );

  // Mul/div and HI/LO reads wait until the running op reaches its last cycle.
  assign cnt_zero_s  = (cnt_r == CNT_ZERO);
  assign interlock_s = (state_r == ST_BUSY) && !cnt_zero_s &&
                       (dec_s.is_md || (dec_s.hilo_rd != HILO_NONE));
  assign o_ready     = !i_hold && !interlock_s;
  assign accept_s    = i_valid && o_ready;

  // Sequencer next state: launch, count down, finish or reload back-to-back.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    md_done_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && dec_s.is_md) begin
          state_nxt_s = ST_BUSY;
          cnt_nxt_s   = CNT_RELOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_zero_s) begin
          md_done_nxt_s = 1'b1;
          if (accept_s && dec_s.is_md) begin
            state_nxt_s = ST_BUSY;
            cnt_nxt_s   = CNT_RELOAD;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Sequencer state, counter and its status flops; runs even while held.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      o_md_busy <= 1'b0;
      o_md_done <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      o_md_busy <= (state_nxt_s == ST_BUSY);
      o_md_done <= md_done_nxt_s;
    end
  end

  // Output register: load on accept, freeze on hold, start is a pure pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid      <= 1'b0;
      o_aluControl <= 6'h00;
      o_ALUSrc_op1 <= 1'b0;
      o_illegal    <= 1'b0;
      o_md_start   <= 1'b0;
      o_md_op      <= 2'b00;
      o_hilo_rd    <= 2'b00;
    end else if (i_hold) begin
      o_md_start   <= 1'b0;
    end else if (accept_s) begin
      o_valid      <= 1'b1;
      o_aluControl <= dec_s.ctrl;
      o_ALUSrc_op1 <= dec_s.op1_sel;
      o_illegal    <= dec_s.illegal;
      o_md_start   <= dec_s.is_md;
      o_md_op      <= dec_s.md_op;
      o_hilo_rd    <= dec_s.hilo_rd;
    end else begin
      o_valid      <= 1'b0;
      o_md_start   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares each presented output.
module tb_alu_ctrl_seq;

  typedef struct {
    string      nm;
    logic [5:0] ctrl;
    logic       op1;
    logic       ill;
    logic       start;
    logic [1:0] mdop;
    logic [1:0] hilo;
  } exp_t;

  logic clk = 1'b0;
  logic rst, rst8, valid, hold;
  logic [5:0] aluop, func;
  logic hold_q = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   busy_watch = 1'b0;
  exp_t sb[$];
  int   start_q[$];
  int   done_q[$];

  // main DUT: MD_EN=1, MD_CYCLES=4
  logic       rdy, ov, op1, ill, mst, mbusy, mdone;
  logic [5:0] ctrl;
  logic [1:0] mop, hilo;
  // reset-test DUT: MD_CYCLES=8
  logic       rdy8, ov8, op18, ill8, mst8, mbusy8, mdone8;
  logic [5:0] ctrl8;
  logic [1:0] mop8, hilo8;
  // MD_EN=0 DUT
  logic       rdy0, ov0, op10, ill0, mst0, mbusy0, mdone0;
  logic [5:0] ctrl0;
  logic [1:0] mop0, hilo0;

  alu_ctrl_seq #(.MD_EN(1'b1), .MD_CYCLES(4)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_aluOp(aluop), .i_func(func),
    .i_hold(hold), .o_ready(rdy), .o_valid(ov), .o_aluControl(ctrl),
    .o_ALUSrc_op1(op1), .o_illegal(ill), .o_md_start(mst), .o_md_op(mop),
    .o_md_busy(mbusy), .o_md_done(mdone), .o_hilo_rd(hilo));

  alu_ctrl_seq #(.MD_EN(1'b1), .MD_CYCLES(8)) u_dut8 (
    .i_clk(clk), .i_rst(rst8), .i_valid(valid), .i_aluOp(aluop), .i_func(func),
    .i_hold(hold), .o_ready(rdy8), .o_valid(ov8), .o_aluControl(ctrl8),
    .o_ALUSrc_op1(op18), .o_illegal(ill8), .o_md_start(mst8), .o_md_op(mop8),
    .o_md_busy(mbusy8), .o_md_done(mdone8), .o_hilo_rd(hilo8));

  alu_ctrl_seq #(.MD_EN(1'b0), .MD_CYCLES(32)) u_md0 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_aluOp(aluop), .i_func(func),
    .i_hold(hold), .o_ready(rdy0), .o_valid(ov0), .o_aluControl(ctrl0),
    .o_ALUSrc_op1(op10), .o_illegal(ill0), .o_md_start(mst0), .o_md_op(mop0),
    .o_md_busy(mbusy0), .o_md_done(mdone0), .o_hilo_rd(hilo0));

  always #5 clk = ~clk;

  // cycle counter and hold history used by the monitor
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    hold_q <= hold;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // scoreboard monitor: a freshly loaded output appears when o_valid is set
  // and the previous edge was not a hold
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (ov && !hold_q) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got ctrl 0x%0h with empty scoreboard", ctrl);
        end else begin
          e = sb.pop_front();
          chk({e.nm, ".ctrl"},    32'(ctrl),  32'(e.ctrl));
          chk({e.nm, ".op1"},     32'(op1),   32'(e.op1));
          chk({e.nm, ".illegal"}, 32'(ill),   32'(e.ill));
          chk({e.nm, ".start"},   32'(mst),   32'(e.start));
          chk({e.nm, ".hilo"},    32'(hilo),  32'(e.hilo));
          if (e.start) chk({e.nm, ".md_op"}, 32'(mop), 32'(e.mdop));
        end
      end else begin
        chk("md_start_without_load", 32'(mst), 32'd0);
      end
      if (mst)   start_q.push_back(cyc);
      if (mdone) done_q.push_back(cyc);
      if (busy_watch) chk("md_busy_window", 32'(mbusy), 32'd1);
    end
  end

  task automatic issue(input string nm, input logic [5:0] op, input logic [5:0] fn,
                       input logic [5:0] ectrl, input logic eop1, input logic eill,
                       input logic estart, input logic [1:0] emdop, input logic [1:0] ehilo,
                       output int stalls);
    exp_t e;
    bit   ok;
    valid = 1'b1;
    aluop = op;
    func  = fn;
    stalls = 0;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      #1;
      if (rdy) begin
        e.nm = nm; e.ctrl = ectrl; e.op1 = eop1; e.ill = eill;
        e.start = estart; e.mdop = emdop; e.hilo = ehilo;
        sb.push_back(e);
        ok = 1'b1;
      end else begin
        stalls++;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_accept_timeout: got ready 0 for 20 cycles, expected acceptance", nm);
      valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 time units, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int mflo_cyc;
    bit seen;
    rst = 1'b1; rst8 = 1'b1; valid = 1'b0; hold = 1'b0;
    aluop = 6'h00; func = 6'h00;
    repeat (2) @(negedge clk);
    #1;
    // reset state
    chk("rst_valid", 32'(ov), 32'd0);
    chk("rst_ctrl",  32'(ctrl), 32'd0);
    chk("rst_illegal", 32'(ill), 32'd0);
    chk("rst_busy",  32'(mbusy), 32'd0);
    chk("rst_done",  32'(mdone), 32'd0);
    chk("rst_hilo",  32'(hilo), 32'd0);
    chk("rst_ready", 32'(rdy), 32'd1);
    @(negedge clk);
    rst = 1'b0; rst8 = 1'b0;
    @(negedge clk);

    // reset in the middle of a mul/div on the MD_CYCLES=8 instance
    start_q.delete(); done_q.delete();
    issue("mult_a", 6'h00, 6'h18, 6'h00, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, st);
    valid = 1'b0;
    repeat (2) @(negedge clk);   // counter of u_dut8 now 5
    rst8 = 1'b1;
    @(negedge clk);
    chk("rst8_busy",  32'(mbusy8), 32'd0);
    chk("rst8_valid", 32'(ov8), 32'd0);
    chk("rst8_done",  32'(mdone8), 32'd0);
    chk("rst8_ready", 32'(rdy8), 32'd1);
    rst8 = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (mdone8) seen = 1'b1;
    end
    chk("rst8_no_done", 32'(seen), 32'd0);
    chk("rst8_idle_busy", 32'(mbusy8), 32'd0);
    chk("mult_a_done_count", 32'(done_q.size()), 32'd1);
    if (done_q.size() == 1 && start_q.size() == 1)
      chk("mult_a_latency", 32'(done_q[0] - start_q[0]), 32'd4);

    // decode stream, back to back
    issue("addi",  6'h08, 6'h00, 6'h20, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, st);
    issue("beq",   6'h04, 6'h00, 6'h22, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, st);
    issue("sll",   6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, st);
    issue("ori",   6'h0D, 6'h11, 6'h25, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, st);
    issue("sltiu", 6'h0B, 6'h00, 6'h2B, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, st);
    issue("f3f",   6'h00, 6'h3F, 6'h00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, st);
    issue("sra",   6'h00, 6'h03, 6'h03, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, st);
    issue("sub",   6'h00, 6'h22, 6'h22, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, st);
    issue("lui",   6'h0F, 6'h00, 6'h3C, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, st);
    issue("slti",  6'h0A, 6'h00, 6'h2A, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, st);
    issue("sw",    6'h2B, 6'h00, 6'h20, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, st);
    issue("j",     6'h02, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, st);
    issue("op3f",  6'h3F, 6'h20, 6'h00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, st);
    issue("mfhi",  6'h00, 6'h10, 6'h00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, st);
    idle(3);

    // MULT, ADD, MFLO: MFLO waits for the last counting cycle
    start_q.delete(); done_q.delete();
    issue("mult",  6'h00, 6'h18, 6'h00, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, st);
    chk("md0_mult_illegal", 32'(ill0), 32'd1);
    chk("md0_mult_start",   32'(mst0), 32'd0);
    chk("md0_mult_busy",    32'(mbusy0), 32'd0);
    issue("add",   6'h00, 6'h20, 6'h20, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, st);
    chk("add_no_stall", 32'(st), 32'd0);
    issue("mflo",  6'h00, 6'h12, 6'h00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, st);
    mflo_cyc = cyc;
    chk("mflo_stalls", 32'(st), 32'd2);
    chk("md0_mflo_illegal", 32'(ill0), 32'd1);
    chk("md0_mflo_hilo",    32'(hilo0), 32'd0);
    idle(6);
    chk("md0_busy_after", 32'(mbusy0), 32'd0);
    chk("mult_done_count", 32'(done_q.size()), 32'd1);
    if (done_q.size() == 1) begin
      chk("mult_done_with_mflo", 32'(done_q[0]), 32'(mflo_cyc));
      if (start_q.size() == 1)
        chk("mult_latency", 32'(done_q[0] - start_q[0]), 32'd4);
    end

    // DIV then DIVU back to back
    start_q.delete(); done_q.delete();
    issue("div",   6'h00, 6'h1A, 6'h00, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, st);
    busy_watch = 1'b1;
    issue("divu",  6'h00, 6'h1B, 6'h00, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00, st);
    chk("divu_stalls", 32'(st), 32'd3);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    busy_watch = 1'b0;
    idle(3);
    chk("divu_busy_end", 32'(mbusy), 32'd0);
    chk("div_start_count", 32'(start_q.size()), 32'd2);
    chk("div_done_count",  32'(done_q.size()), 32'd2);
    if (start_q.size() == 2 && done_q.size() == 2) begin
      chk("div_issue_gap", 32'(start_q[1] - start_q[0]), 32'd4);
      chk("div_latency",   32'(done_q[0] - start_q[0]), 32'd4);
      chk("divu_latency",  32'(done_q[1] - start_q[1]), 32'd4);
    end

    // hold for 3 cycles with ANDI presented
    issue("ori_h", 6'h0D, 6'h00, 6'h25, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, st);
    hold = 1'b1;
    aluop = 6'h0C;
    func = 6'h00;
    #1;
    chk("hold_ready", 32'(rdy), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("hold_ready", 32'(rdy), 32'd0);
      chk("hold_ctrl",  32'(ctrl), 32'h25);
      chk("hold_valid", 32'(ov), 32'd1);
    end
    hold = 1'b0;
    issue("andi",  6'h0C, 6'h00, 6'h24, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, st);
    chk("andi_no_stall", 32'(st), 32'd0);
    chk("andi_valid", 32'(ov), 32'd1);
    idle(4);
    chk("andi_valid_drop", 32'(ov), 32'd0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
